// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle RISC-V controller: FSM states, opcodes,
// ALU control encodings and the per-state control word.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write = 1'b1; c.pc_update = 1'b1;
        c.alu_src_b = 2'b10; c.result_src = 2'b10;
      end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    c.reg_write = 1'b1;
      BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and flags in, datapath controls out; the controller
// takes the master side, the datapath the slave side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );
  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// ALU operation decoder: ALUOp selects add/sub directly or defers to funct3.
module aludec
  import multicycle_controller_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      2'b10: begin
        case (funct3)
          // sub only for R-type with funct7b5; addi ignores bit 30
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller: Moore FSM with registered control word,
// combinational PCWrite/ImmSrc/ALUControl.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  multicycle_controller_if.master bus
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl;

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = MEMWB;
      EXECUTER, EXECUTEI, JAL: state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  // control word is registered alongside the state so outputs are glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      ctrl_q <= state_ctrl(FETCH);
    end else begin
      state  <= state_next;
      ctrl_q <= state_ctrl(state_next);
    end
  end

  // reset shows FETCH controls immediately, with every write enable held off
  assign ctrl = reset ? state_ctrl(FETCH) : ctrl_q;

  assign bus.PCWrite   = ~reset & (ctrl.pc_update | (ctrl.branch & bus.Zero));
  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.MemWrite  = ~reset & ctrl.mem_write;
  assign bus.IRWrite   = ~reset & ctrl.ir_write;
  assign bus.RegWrite  = ~reset & ctrl.reg_write;
  assign bus.ResultSrc = ctrl.result_src;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  aludec u_aludec (
    .op5        (bus.op[5]),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .ALUOp      (ctrl.alu_op),
    .ALUControl (bus.ALUControl)
  );

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk in 1, core clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have input op in 7, instruction opcode [6:0].
REQ-003 SHALL have input funct3 in 3, instruction [14:12].
REQ-004 SHALL have input funct7b5 in 1, instruction bit 30.
REQ-005 SHALL have input Zero in 1, ALU zero flag.
REQ-006 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, each 1 bit: write enables and address select for the shared datapath.
REQ-007 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, each 2 bits; and ALUControl, 3 bits.

Function
REQ-008 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-009 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: lw(0000011)/sw(0100011)->MEMADR; R(0110011)->EXECUTER; I(0010011)->EXECUTEI; jal(1101111)->JAL; beq(1100011)->BEQ; any other op->FETCH.
- MEMADR: lw->MEMREAD, else MEMWRITE.
- MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB.
- MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
REQ-010 Unlisted outputs SHALL be 0 in every state.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-011 PCWrite SHALL equal PCUpdate | (Branch & Zero), combinationally, in the same cycle.
REQ-012 ImmSrc SHALL be combinational from op, independent of state: lw/I 00, sw 01, beq 10, jal 11, others 00.
REQ-013 ALUControl SHALL be decoded from internal 2-bit ALUOp:
- ALUOp 00: add (000); 01: sub (001).
- ALUOp 10, by funct3: 000 sub if op[5]&funct7b5, else add; 010 slt (101); 110 or (011); 111 and (010); any other funct3 000.
- ALUOp 11: 000.
REQ-014 Instruction latency in cycles, FETCH to FETCH re-entry: lw 5; sw, R, I and jal 4; beq 3; unsupported op 2.
REQ-015 A change on op/funct3/funct7b5 SHALL affect state only through the transitions in REQ-009; no output SHALL depend on Zero except PCWrite.

Reset
REQ-016 With reset high at a clk rising edge, the state SHALL become FETCH, regardless of the current state; this includes mid-instruction resets, such as from MEMWRITE.
REQ-017 While reset is high, PCWrite, MemWrite, IRWrite and RegWrite SHALL be forced to 0; other outputs SHALL show FETCH values.

Structure
REQ-018 A shared package SHALL hold the state enum, the opcode localparams, and the ALUControl encodings.
REQ-019 ALU decoding (REQ-013) SHALL be a sub-module aludec with inputs op[5], funct3, funct7b5 and ALUOp, and output ALUControl; the rest SHALL be the FSM and the ImmSrc decoder.

Verification
REQ-020 The bench SHALL cover these scenarios:
- reset high 2 cycles, op=0000011 -> state FETCH, all write enables 0. After release, the sequence SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with RegWrite=1 only in MEMWB.
- op=0100011 -> MemWrite=1 and AdrSrc=1 exactly in the 4th cycle; RegWrite never 1.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER. With funct3=110 -> 011. Then ALUWB with RegWrite=1.
- op=1100011 held 3 cycles, Zero=1 in BEQ -> PCWrite=1. Zero=0 -> PCWrite=0. Next state FETCH in both cases.
- op=1101111 -> ImmSrc=11, and PCWrite=1 in JAL, then ALUWB RegWrite=1.
- op=1111111 -> DECODE->FETCH with no write enable asserted; reset asserted in MEMWRITE -> FETCH next cycle, and MemWrite=0 in that cycle.
